// File: rtl/sram_arb_pkg.sv
// Shared types and AHB-Lite encodings used by the SRAM arbiter.
package sram_arb_pkg;

  typedef enum logic [1:0] {
    ARB    = 2'd0,
    CPU_DP = 2'd1,
    B_DP   = 2'd2
  } state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [2:0] HSIZE_WORD    = 3'b010;

endpackage

// File: rtl/ahb_sram_arbiter.sv
// Round-robin sharing of one AHB-Lite SRAM slave between the CPU expansion port
// and a level-request word port; one transfer in flight, CPU stalled via HREADYOUT.
module ahb_sram_arbiter
  import sram_arb_pkg::*;
#(
  parameter int ADDR_W = 20,
  parameter int DATA_W = 32
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              S_HSEL,
  input  logic [ADDR_W-1:0] S_HADDR,
  input  logic [1:0]        S_HTRANS,
  input  logic [2:0]        S_HSIZE,
  input  logic              S_HWRITE,
  input  logic [DATA_W-1:0] S_HWDATA,
  input  logic              S_HREADY,
  output logic              S_HREADYOUT,
  output logic [DATA_W-1:0] S_HRDATA,
  output logic              S_HRESP,
  input  logic              B_REQ,
  input  logic              B_WRITE,
  input  logic [ADDR_W-1:0] B_ADDR,
  input  logic [DATA_W-1:0] B_WDATA,
  output logic              B_ACK,
  output logic [DATA_W-1:0] B_RDATA,
  output logic              B_ERR,
  output logic              M_HSEL,
  output logic [ADDR_W-1:0] M_HADDR,
  output logic [1:0]        M_HTRANS,
  output logic [2:0]        M_HSIZE,
  output logic              M_HWRITE,
  output logic [DATA_W-1:0] M_HWDATA,
  output logic              M_HREADY,
  input  logic              M_HREADYOUT,
  input  logic [DATA_W-1:0] M_HRDATA,
  input  logic              M_HRESP
);

  state_t            state_r;
  state_t            state_next_s;
  logic              cpu_pend_r;
  logic              last_b_r;
  logic [ADDR_W-1:0] cpu_addr_r;
  logic [2:0]        cpu_size_r;
  logic              cpu_write_r;
  logic              cpu_capture_s;
  logic              arb_s;
  logic              cpu_grant_s;
  logic              b_grant_s;
  logic              unused_ok_s;

  assign unused_ok_s   = ^{S_HTRANS[0], B_ADDR[1:0]};
  assign cpu_capture_s = S_HSEL & S_HTRANS[1] & S_HREADY;

  // Grants are only issued from ARB; last_b breaks ties so each side waits at most one foreign transfer.
  assign arb_s       = (state_r == ARB) & ~HRESET;
  assign cpu_grant_s = arb_s & cpu_pend_r & (~B_REQ | last_b_r);
  assign b_grant_s   = arb_s & B_REQ & (~cpu_pend_r | ~last_b_r);

  assign M_HREADY = M_HREADYOUT;

  // State register.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_r <= ARB;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ARB: begin
        if (cpu_grant_s) begin
          state_next_s = CPU_DP;
        end else if (b_grant_s) begin
          state_next_s = B_DP;
        end else begin
          state_next_s = ARB;
        end
      end
      CPU_DP, B_DP: begin
        if (M_HREADYOUT) begin
          state_next_s = ARB;
        end else begin
          state_next_s = state_r;
        end
      end
      default: state_next_s = ARB;
    endcase
  end

  // CPU address-phase capture, pending flag and round-robin history.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      cpu_pend_r  <= 1'b0;
      last_b_r    <= 1'b1;
      cpu_addr_r  <= '0;
      cpu_size_r  <= 3'b000;
      cpu_write_r <= 1'b0;
    end else begin
      if (cpu_capture_s) begin
        cpu_pend_r  <= 1'b1;
        cpu_addr_r  <= S_HADDR;
        cpu_size_r  <= S_HSIZE;
        cpu_write_r <= S_HWRITE;
      end else if (cpu_grant_s) begin
        cpu_pend_r <= 1'b0;
      end
      if (cpu_grant_s) begin
        last_b_r <= 1'b0;
      end else if (b_grant_s) begin
        last_b_r <= 1'b1;
      end
    end
  end

  // Output muxing: downstream address phase in ARB, data-phase steering in CPU_DP/B_DP.
  always_comb begin
    M_HSEL      = 1'b0;
    M_HADDR     = '0;
    M_HTRANS    = HTRANS_IDLE;
    M_HSIZE     = 3'b000;
    M_HWRITE    = 1'b0;
    M_HWDATA    = '0;
    S_HREADYOUT = ~cpu_pend_r;
    S_HRESP     = 1'b0;
    S_HRDATA    = '0;
    B_ACK       = 1'b0;
    B_RDATA     = '0;
    B_ERR       = 1'b0;
    case (state_r)
      ARB: begin
        if (cpu_grant_s) begin
          M_HSEL   = 1'b1;
          M_HADDR  = cpu_addr_r;
          M_HTRANS = HTRANS_NONSEQ;
          M_HSIZE  = cpu_size_r;
          M_HWRITE = cpu_write_r;
        end else if (b_grant_s) begin
          M_HSEL   = 1'b1;
          M_HADDR  = {B_ADDR[ADDR_W-1:2], 2'b00};
          M_HTRANS = HTRANS_NONSEQ;
          M_HSIZE  = HSIZE_WORD;
          M_HWRITE = B_WRITE;
        end else begin
          M_HSEL = 1'b0;
        end
      end
      CPU_DP: begin
        M_HWDATA    = S_HWDATA;
        S_HREADYOUT = M_HREADYOUT;
        S_HRESP     = M_HRESP;
        S_HRDATA    = M_HRDATA;
      end
      B_DP: begin
        M_HWDATA = B_WDATA;
        if (M_HREADYOUT) begin
          B_ACK   = 1'b1;
          B_RDATA = M_HRDATA;
          B_ERR   = M_HRESP;
        end else begin
          B_ACK = 1'b0;
        end
      end
      default: begin
        M_HSEL = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_ahb_sram_arbiter.sv
// Bench for ahb_sram_arbiter: behavioural SRAM slave with programmable wait/error,
// a table of single transfers, and hand sequences for arbitration and reset corners.
module tb_ahb_sram_arbiter;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        S_HSEL;
  logic [19:0] S_HADDR;
  logic [1:0]  S_HTRANS;
  logic [2:0]  S_HSIZE;
  logic        S_HWRITE;
  logic [31:0] S_HWDATA;
  logic        S_HREADY;
  logic        S_HREADYOUT;
  logic [31:0] S_HRDATA;
  logic        S_HRESP;
  logic        B_REQ;
  logic        B_WRITE;
  logic [19:0] B_ADDR;
  logic [31:0] B_WDATA;
  logic        B_ACK;
  logic [31:0] B_RDATA;
  logic        B_ERR;
  logic        M_HSEL;
  logic [19:0] M_HADDR;
  logic [1:0]  M_HTRANS;
  logic [2:0]  M_HSIZE;
  logic        M_HWRITE;
  logic [31:0] M_HWDATA;
  logic        M_HREADY;
  logic        M_HREADYOUT;
  logic [31:0] M_HRDATA;
  logic        M_HRESP;

  int checks = 0;
  int errors = 0;

  always #5 HCLK = ~HCLK;

  assign S_HREADY = S_HREADYOUT;

  ahb_sram_arbiter #(.ADDR_W(20), .DATA_W(32)) dut (
    .HCLK(HCLK), .HRESET(HRESET),
    .S_HSEL(S_HSEL), .S_HADDR(S_HADDR), .S_HTRANS(S_HTRANS), .S_HSIZE(S_HSIZE),
    .S_HWRITE(S_HWRITE), .S_HWDATA(S_HWDATA), .S_HREADY(S_HREADY),
    .S_HREADYOUT(S_HREADYOUT), .S_HRDATA(S_HRDATA), .S_HRESP(S_HRESP),
    .B_REQ(B_REQ), .B_WRITE(B_WRITE), .B_ADDR(B_ADDR), .B_WDATA(B_WDATA),
    .B_ACK(B_ACK), .B_RDATA(B_RDATA), .B_ERR(B_ERR),
    .M_HSEL(M_HSEL), .M_HADDR(M_HADDR), .M_HTRANS(M_HTRANS), .M_HSIZE(M_HSIZE),
    .M_HWRITE(M_HWRITE), .M_HWDATA(M_HWDATA), .M_HREADY(M_HREADY),
    .M_HREADYOUT(M_HREADYOUT), .M_HRDATA(M_HRDATA), .M_HRESP(M_HRESP)
  );

  // Behavioural SRAM slave: cfg_wait wait states, or a two-cycle ERROR when cfg_err is set.
  logic [31:0] mem [0:255];
  int          cfg_wait = 0;
  logic        cfg_err = 1'b0;
  logic        sl_act = 1'b0;
  logic        sl_wr = 1'b0;
  logic        sl_err = 1'b0;
  logic        sl_ph2 = 1'b0;
  logic [7:0]  sl_idx = 8'd0;
  int          sl_wait = 0;

  assign M_HREADYOUT = !sl_act ? 1'b1 : (sl_err ? sl_ph2 : (sl_wait == 0));
  assign M_HRESP     = sl_act & sl_err;
  assign M_HRDATA    = (sl_act && !sl_wr && !sl_err && sl_wait == 0) ? mem[sl_idx] : 32'h0;

  always @(posedge HCLK) begin
    if (HRESET) begin
      sl_act <= 1'b0;
    end else begin
      if (sl_act && M_HREADYOUT) begin
        if (sl_wr && !sl_err) mem[sl_idx] <= M_HWDATA;
        sl_act <= 1'b0;
      end else if (sl_act) begin
        if (sl_err) sl_ph2 <= 1'b1;
        else sl_wait <= sl_wait - 1;
      end
      if (M_HREADY && M_HSEL && M_HTRANS[1]) begin
        sl_act  <= 1'b1;
        sl_wr   <= M_HWRITE;
        sl_idx  <= M_HADDR[9:2];
        sl_wait <= cfg_wait;
        sl_err  <= cfg_err;
        sl_ph2  <= 1'b0;
      end
    end
  end

  // Log of downstream address phases, used to check grant order.
  logic        log_en = 1'b0;
  logic [19:0] grant_q [$];
  always @(posedge HCLK) begin
    if (log_en && M_HSEL && M_HTRANS[1] && M_HREADY) grant_q.push_back(M_HADDR);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    HRESET = 1'b1;
    repeat (2) @(posedge HCLK);
    #1;
    HRESET = 1'b0;
  endtask

  task automatic cpu_xfer(input logic wr, input logic [19:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic resp, output logic pre_resp,
                          output int stalls, output logic done);
    S_HSEL = 1'b1; S_HTRANS = 2'b10; S_HADDR = addr; S_HWRITE = wr; S_HSIZE = 3'b010;
    @(posedge HCLK); #1;
    S_HSEL = 1'b0; S_HTRANS = 2'b00; S_HWDATA = wdata;
    stalls = 0; pre_resp = 1'b0; done = 1'b0; rdata = 32'h0; resp = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge HCLK);
      if (S_HREADYOUT) begin
        rdata = S_HRDATA; resp = S_HRESP; done = 1'b1;
      end else begin
        stalls++; pre_resp = S_HRESP;
      end
      @(posedge HCLK); #1;
      if (done) break;
    end
  endtask

  task automatic b_xfer(input logic wr, input logic [19:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rdata, output logic err, output int cycles,
                        output logic done);
    B_REQ = 1'b1; B_WRITE = wr; B_ADDR = addr; B_WDATA = wdata;
    done = 1'b0; cycles = 0; rdata = 32'h0; err = 1'b0;
    for (int k = 0; k < 30; k++) begin
      @(negedge HCLK);
      if (B_ACK) begin
        rdata = B_RDATA; err = B_ERR; cycles = k + 1; done = 1'b1;
      end
      @(posedge HCLK); #1;
      if (done) break;
    end
    B_REQ = 1'b0;
  endtask

  typedef struct {
    logic        is_b;
    logic        wr;
    logic [19:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic        err;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_cycles;
    logic        exp_pre;
  } vec_t;

  localparam int NV = 11;
  vec_t vecs [NV];

  logic [31:0] rd;
  logic        rsp;
  logic        pre;
  logic        ok;
  int          cyc;
  logic [19:0] exp_grant [8];

  initial begin
    // CPU: stalls = ARB cycle + slave waits (+1 for the first ERROR cycle); B: cycles from request to B_ACK inclusive.
    vecs[0]  = '{1'b0, 1'b1, 20'h00010, 32'h12345678, 0, 1'b0, 32'h00000000, 1'b0, 1, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 20'h00010, 32'h00000000, 0, 1'b0, 32'h12345678, 1'b0, 1, 1'b0};
    vecs[2]  = '{1'b1, 1'b1, 20'h00020, 32'hCAFEF00D, 0, 1'b0, 32'h00000000, 1'b0, 2, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 20'h00020, 32'h00000000, 2, 1'b0, 32'hCAFEF00D, 1'b0, 4, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 20'h00020, 32'h00000000, 1, 1'b0, 32'hCAFEF00D, 1'b0, 2, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 20'h00013, 32'hA5A55A5A, 0, 1'b0, 32'h00000000, 1'b0, 2, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 20'h00010, 32'h00000000, 0, 1'b0, 32'hA5A55A5A, 1'b0, 1, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 20'h00030, 32'h0BADBEEF, 0, 1'b1, 32'h00000000, 1'b1, 2, 1'b1};
    vecs[8]  = '{1'b1, 1'b0, 20'h00030, 32'h00000000, 0, 1'b1, 32'h00000000, 1'b1, 3, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 20'h0003C, 32'h76543210, 3, 1'b0, 32'h00000000, 1'b0, 4, 1'b0};
    vecs[10] = '{1'b1, 1'b0, 20'h0003C, 32'h00000000, 0, 1'b0, 32'h76543210, 1'b0, 2, 1'b0};
    exp_grant = '{20'h00100, 20'h00200, 20'h00104, 20'h00204,
                  20'h00108, 20'h00208, 20'h0010C, 20'h0020C};

    HRESET = 1'b1; S_HSEL = 1'b0; S_HADDR = 20'h0; S_HTRANS = 2'b00; S_HSIZE = 3'b000;
    S_HWRITE = 1'b0; S_HWDATA = 32'h0; B_REQ = 1'b0; B_WRITE = 1'b0; B_ADDR = 20'h0;
    B_WDATA = 32'h0;
    do_reset();

    @(negedge HCLK);
    chk("rst S_HREADYOUT", 32'(S_HREADYOUT), 32'd1);
    chk("rst S_HRESP", 32'(S_HRESP), 32'd0);
    chk("rst S_HRDATA", S_HRDATA, 32'h0);
    chk("rst B_ACK", 32'(B_ACK), 32'd0);
    chk("rst B_ERR", 32'(B_ERR), 32'd0);
    chk("rst B_RDATA", B_RDATA, 32'h0);
    chk("rst M_ctrl", {24'h0, M_HSEL, M_HTRANS, M_HSIZE, M_HWRITE, M_HREADY}, 32'h1);
    chk("rst M_HADDR", 32'(M_HADDR), 32'h0);
    chk("rst M_HWDATA", M_HWDATA, 32'h0);
    @(posedge HCLK); #1;

    // IDLE with HSEL is a zero-wait OKAY and is not forwarded.
    S_HSEL = 1'b1; S_HTRANS = 2'b00; S_HADDR = 20'h00044;
    @(posedge HCLK); #1;
    S_HSEL = 1'b0;
    @(negedge HCLK);
    chk("idle S_HREADYOUT", 32'(S_HREADYOUT), 32'd1);
    chk("idle M_HTRANS", 32'(M_HTRANS), 32'd0);
    @(posedge HCLK); #1;

    for (int i = 0; i < NV; i++) begin
      cfg_wait = vecs[i].waits;
      cfg_err  = vecs[i].err;
      if (vecs[i].is_b) begin
        b_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, rsp, cyc, ok);
        chk($sformatf("v%0d b_done", i), 32'(ok), 32'd1);
        chk($sformatf("v%0d B_RDATA", i), rd, vecs[i].exp_rdata);
        chk($sformatf("v%0d B_ERR", i), 32'(rsp), 32'(vecs[i].exp_err));
        chk($sformatf("v%0d b_cycles", i), 32'(cyc), 32'(vecs[i].exp_cycles));
      end else begin
        cpu_xfer(vecs[i].wr, vecs[i].addr, vecs[i].wdata, rd, rsp, pre, cyc, ok);
        chk($sformatf("v%0d cpu_done", i), 32'(ok), 32'd1);
        chk($sformatf("v%0d S_HRDATA", i), rd, vecs[i].exp_rdata);
        chk($sformatf("v%0d S_HRESP", i), 32'(rsp), 32'(vecs[i].exp_err));
        chk($sformatf("v%0d stalls", i), 32'(cyc), 32'(vecs[i].exp_cycles));
        chk($sformatf("v%0d pre_resp", i), 32'(pre), 32'(vecs[i].exp_pre));
      end
    end
    cfg_wait = 0; cfg_err = 1'b0;

    // CPU address phase while B owns the data phase.
    B_REQ = 1'b1; B_WRITE = 1'b0; B_ADDR = 20'h00020;
    @(negedge HCLK);
    chk("cb B_ACK c0", 32'(B_ACK), 32'd0);
    @(posedge HCLK); #1;
    S_HSEL = 1'b1; S_HTRANS = 2'b10; S_HADDR = 20'h00010; S_HWRITE = 1'b0; S_HSIZE = 3'b010;
    @(negedge HCLK);
    chk("cb B_ACK c1", 32'(B_ACK), 32'd1);
    chk("cb B_RDATA", B_RDATA, 32'hCAFEF00D);
    chk("cb S_HREADYOUT c1", 32'(S_HREADYOUT), 32'd1);
    @(posedge HCLK); #1;
    B_REQ = 1'b0; S_HSEL = 1'b0; S_HTRANS = 2'b00;
    @(negedge HCLK);
    chk("cb S_HREADYOUT c2", 32'(S_HREADYOUT), 32'd0);
    chk("cb B_ACK c2", 32'(B_ACK), 32'd0);
    chk("cb M_HADDR c2", 32'(M_HADDR), 32'h00010);
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("cb S_HREADYOUT c3", 32'(S_HREADYOUT), 32'd1);
    chk("cb S_HRDATA c3", S_HRDATA, 32'hA5A55A5A);
    @(posedge HCLK); #1;

    // Reset while the CPU data phase is waiting on the slave.
    cfg_wait = 3;
    S_HSEL = 1'b1; S_HTRANS = 2'b10; S_HADDR = 20'h0003C; S_HWRITE = 1'b0;
    @(posedge HCLK); #1;
    S_HSEL = 1'b0; S_HTRANS = 2'b00;
    @(posedge HCLK); #1;
    @(negedge HCLK);
    chk("rm in CPU_DP", 32'(S_HREADYOUT), 32'd0);
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    cfg_wait = 0;
    @(negedge HCLK);
    chk("rm S_HREADYOUT", 32'(S_HREADYOUT), 32'd1);
    chk("rm M_HTRANS", 32'(M_HTRANS), 32'd0);
    chk("rm B_ACK", 32'(B_ACK), 32'd0);
    chk("rm S_HRDATA", S_HRDATA, 32'h0);
    @(posedge HCLK); #1;
    cpu_xfer(1'b0, 20'h00010, 32'h0, rd, rsp, pre, cyc, ok);
    chk("rm cpu rdata", rd, 32'hA5A55A5A);
    chk("rm cpu stalls", 32'(cyc), 32'd1);
    b_xfer(1'b0, 20'h00020, 32'h0, rd, rsp, cyc, ok);
    chk("rm b rdata", rd, 32'hCAFEF00D);
    chk("rm b cycles", 32'(cyc), 32'd2);

    // Both sides requesting continuously after reset: grants alternate, CPU first.
    do_reset();
    grant_q.delete();
    log_en = 1'b1;
    fork
      begin : cpu_stream
        int   acc;
        logic rdy;
        acc = 0;
        S_HSEL = 1'b1; S_HTRANS = 2'b10; S_HWRITE = 1'b0; S_HSIZE = 3'b010; S_HADDR = 20'h00100;
        for (int k = 0; k < 60 && acc < 4; k++) begin
          @(negedge HCLK);
          rdy = S_HREADYOUT;
          @(posedge HCLK); #1;
          if (rdy) begin
            acc++;
            if (acc < 4) S_HADDR = 20'h00100 + 20'(4 * acc);
            else begin S_HSEL = 1'b0; S_HTRANS = 2'b00; end
          end
        end
      end
      begin : b_stream
        int   acks;
        logic ack;
        acks = 0;
        @(posedge HCLK); #1;
        B_REQ = 1'b1; B_WRITE = 1'b0; B_ADDR = 20'h00200;
        for (int k = 0; k < 60 && acks < 4; k++) begin
          @(negedge HCLK);
          ack = B_ACK;
          @(posedge HCLK); #1;
          if (ack) begin
            acks++;
            if (acks < 4) B_ADDR = 20'h00200 + 20'(4 * acks);
            else B_REQ = 1'b0;
          end
        end
      end
    join
    repeat (6) @(posedge HCLK);
    #1;
    log_en = 1'b0;
    chk("rr grant count", 32'(grant_q.size()), 32'd8);
    for (int g = 0; g < 8; g++) begin
      if (g < grant_q.size()) chk($sformatf("rr grant %0d", g), 32'(grant_q[g]), 32'(exp_grant[g]));
      else chk($sformatf("rr grant %0d missing", g), 32'hFFFFFFFF, 32'(exp_grant[g]));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
